apb_regfile_slave: RTL and testbench

Parametrised APB4 slave with a configurable register file, programmable wait states, byte strobes and error response. It is the next generation of the bus-side endpoint in the APB/SPI subsystem. It sits behind the APB master and exposes read/write control registers and read-only hardware status registers to the SPI datapath. It adds `pslverr`, `pstrb` and `pready` wait-state generation, none of which the earlier slave modport supported.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_regfile_slave_if.sv | 36 +++
 rtl/apb_reg_bank.sv | 81 ++++++++
 rtl/apb_regfile_slave.sv | 154 +++++++++++++++
 tb/tb_apb_regfile_slave.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB register-file slave.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // log2 of the number of byte lanes in a DW-bit data word (8->0, 16->1, 32->2)
  function automatic int clog2_bytes(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 8; i++) begin
      if ((1 << i) <= (dw / 8)) r = i;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regfile_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// apb_regfile_slave_if
// APB4 bus bundle with master and slave views.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
interface apb_regfile_slave_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
);

  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// apb_reg_bank
// Register array with byte-strobe merge, RO status muxing and write pulses.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int              DW      = APB_DW,
  parameter int              NREG    = 8,
  parameter int              IW      = 3,
  parameter logic [NREG-1:0] RO_MASK = '0,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               we,
  input  logic [IW-1:0]      wr_idx,
  input  logic [DW-1:0]      wdata,
  input  logic [DW/8-1:0]    wstrb,
  input  logic [IW-1:0]      rd_idx,
  output logic [DW-1:0]      rd_data,
  input  logic [NREG*DW-1:0] status_i,
  output logic [NREG*DW-1:0] reg_q,
  output logic [NREG-1:0]    wr_pulse
);

  localparam int BL = DW / 8;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] wr_pulse_q;
  logic [NREG-1:0] wr_pulse_d;

  // Merge enabled byte lanes into the addressed register; RO entries never take writes
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i]     = regs_q[i];
      wr_pulse_d[i] = 1'b0;
      if (we && (wr_idx == IW'(i)) && !RO_MASK[i]) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < BL; b++) begin
          if (wstrb[b]) regs_d[i][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Register storage; reset overrides a write committed on the same edge
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read source: live status for RO entries, stored value otherwise
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_idx == IW'(i)) begin
        rd_data = RO_MASK[i] ? status_i[i*DW +: DW] : regs_q[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign reg_q[g*DW +: DW] = regs_q[g];
    end
  endgenerate

  assign wr_pulse = wr_pulse_q;

endmodule
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// apb_regfile_slave
// APB4 slave: access FSM, wait-state counter, address decode and error
// response in front of a parameterised register bank.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int              AW          = APB_AW,
  parameter int              DW          = APB_DW,
  parameter int              NREG        = 8,
  parameter int              WAIT_STATES = 0,
  parameter logic [NREG-1:0] RO_MASK     = '0,
  parameter logic [DW-1:0]   RST_VAL     = '0
) (
  input  logic                pclk,
  input  logic                preset,
  apb_regfile_slave_if.slave  bus,
  input  logic [NREG*DW-1:0]  status_i,
  output logic [NREG*DW-1:0]  reg_q,
  output logic [NREG-1:0]     wr_pulse
);

  localparam int         LB = clog2_bytes(DW);
  localparam int         IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  apb_state_e    state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] prdata_q, prdata_d;
  logic          err_q, err_d;
  logic          write_q, write_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [AW-1:0] idx_full;
  logic [IW-1:0] idx_a;
  logic          in_range;
  logic          misaligned;
  logic          ro_hit;
  logic          setup;
  logic          last;
  logic          commit;
  logic [DW-1:0] rd_data;

  assign idx_full = bus.paddr >> LB;
  assign idx_a    = idx_full[IW-1:0];
  assign in_range = (idx_full < AW'(NREG));

  generate
    if (LB > 0) begin : g_align
      assign misaligned = |bus.paddr[LB-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // Flag whether the decoded index lands on a read-only register
  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if ((idx_a == IW'(i)) && RO_MASK[i]) ro_hit = 1'b1;
    end
  end

  assign setup  = (state_q == IDLE) & bus.psel & ~bus.penable;
  assign last   = (state_q == ACCESS) & bus.psel & bus.penable & (wcnt_q == WS);
  assign commit = last & write_q & ~err_q;

  assign bus.pready  = last;
  assign bus.pslverr = last & err_q;
  assign bus.prdata  = prdata_q;

  // Next-state: decode and capture read data at setup, count waits in access
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    write_d  = write_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d  = ACCESS;
          wcnt_d   = '0;
          err_d    = ~in_range | misaligned | (bus.pwrite & ro_hit);
          write_d  = bus.pwrite;
          idx_d    = idx_a;
          prdata_d = (bus.pwrite | ~in_range | misaligned) ? '0 : rd_data;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          // master abandoned the transfer: nothing is committed
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (last) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (bus.penable && (wcnt_q != WS)) begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // FSM and captured-transfer registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      prdata_q <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
    end
  end

  apb_reg_bank #(
    .DW      (DW),
    .NREG    (NREG),
    .IW      (IW),
    .RO_MASK (RO_MASK),
    .RST_VAL (RST_VAL)
  ) u_bank (
    .pclk     (pclk),
    .preset   (preset),
    .we       (commit),
    .wr_idx   (idx_q),
    .wdata    (bus.pwdata),
    .wstrb    (bus.pstrb),
    .rd_idx   (idx_a),
    .rd_data  (rd_data),
    .status_i (status_i),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_regfile_slave
// Scoreboard bench: a zero-wait and a three-wait slave share one stimulus
// bus; psel is steered to one of them at a time.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_apb_regfile_slave;
  import apb_pkg::*;

  localparam int          NREG = 8;
  localparam logic [31:0] RSTV = 32'hA5A5_0000;
  localparam logic [7:0]  ROM  = 8'b0000_1000;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic        sel;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [NREG*32-1:0] status_v;
  logic [NREG*32-1:0] rq0, rq1;
  logic [NREG-1:0]    wp0, wp1;

  apb_regfile_slave_if #(.AW(32), .DW(32)) bus0 ();
  apb_regfile_slave_if #(.AW(32), .DW(32)) bus1 ();

  assign bus0.psel    = psel & ~sel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus1.psel    = psel & sel;
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata;
  assign bus1.pstrb   = pstrb;

  apb_regfile_slave #(
    .AW(32), .DW(32), .NREG(NREG), .WAIT_STATES(0), .RO_MASK(ROM), .RST_VAL(RSTV)
  ) dut0 (
    .pclk(pclk), .preset(preset), .bus(bus0),
    .status_i(status_v), .reg_q(rq0), .wr_pulse(wp0)
  );

  apb_regfile_slave #(
    .AW(32), .DW(32), .NREG(NREG), .WAIT_STATES(3), .RO_MASK(ROM), .RST_VAL(RSTV)
  ) dut1 (
    .pclk(pclk), .preset(preset), .bus(bus1),
    .status_i(status_v), .reg_q(rq1), .wr_pulse(wp1)
  );

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;
  logic [7:0]  wp_m;
  assign pready_m  = sel ? bus1.pready  : bus0.pready;
  assign pslverr_m = sel ? bus1.pslverr : bus0.pslverr;
  assign prdata_m  = sel ? bus1.prdata  : bus0.prdata;
  assign wp_m      = sel ? wp1 : wp0;

  typedef struct {
    logic [31:0] rd;
    bit          err;
    bit          wr;
    logic [7:0]  pulse;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m0 [NREG];
  logic [31:0] m1 [NREG];
  int          n_chk;
  int          n_pass;
  int          w;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic models_reset();
    for (int i = 0; i < NREG; i++) begin
      m0[i] = RSTV;
      m1[i] = RSTV;
    end
  endtask

  task automatic check_regs(input bit d);
    for (int i = 0; i < NREG; i++) begin
      if (d) chk($sformatf("dut1_reg%0d", i), rq1[i*32 +: 32], m1[i]);
      else   chk($sformatf("dut0_reg%0d", i), rq0[i*32 +: 32], m0[i]);
    end
  endtask

  task automatic idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // One APB transfer; expectation built from the bench model and pushed before driving
  task automatic xfer(input bit d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, output int waits);
    exp_t e, got;
    int   idx;
    bit   ready;
    idx   = int'(addr >> 2);
    e.wr  = wr;
    e.err = (idx >= NREG) || (addr[1:0] != 2'b00);
    if (!e.err && wr && ROM[idx]) e.err = 1'b1;
    e.rd    = '0;
    e.pulse = '0;
    if (!e.err) begin
      if (wr) begin
        e.pulse = 8'(1 << idx);
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) begin
            if (d) m1[idx][8*b +: 8] = data[8*b +: 8];
            else   m0[idx][8*b +: 8] = data[8*b +: 8];
          end
        end
      end else if (ROM[idx]) begin
        e.rd = status_v[idx*32 +: 32];
      end else begin
        e.rd = d ? m1[idx] : m0[idx];
      end
    end
    sb_q.push_back(e);

    sel = d; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #4;
      if (pready_m === 1'b1) begin
        ready = 1'b1;
        break;
      end
      if (!wr) chk("rd_hold", prdata_m, e.rd);
      status_v[3*32 +: 32] = status_v[3*32 +: 32] ^ 32'hFFFF_0000;
      waits++;
      @(posedge pclk); #1;
    end
    got = sb_q.pop_front();
    if (!ready) begin
      chk("pready_timeout", pready_m, 1);
    end else begin
      chk("pslverr", pslverr_m, got.err);
      if (!got.wr) chk("prdata", prdata_m, got.rd);
    end
    @(posedge pclk); #1;
    chk("wr_pulse", wp_m, got.pulse);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int i = 0; i < NREG; i++) status_v[i*32 +: 32] = 32'h5A5A_0000 | 32'(i);
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    models_reset();

    // reset state
    check_regs(0);
    check_regs(1);
    chk("rst_pready",  bus0.pready,  0);
    chk("rst_pslverr", bus0.pslverr, 0);
    chk("rst_prdata0", bus0.prdata,  0);
    chk("rst_prdata1", bus1.prdata,  0);
    chk("rst_wp0", wp0, 0);
    chk("rst_wp1", wp1, 0);

    // zero-wait write then immediate read of the same register
    xfer(0, 1'b1, 32'h04, 32'h1234_5678, 4'hF, w); chk("zw_wr_waits", w, 0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, w);         chk("zw_rd_waits", w, 0);

    // byte strobes
    xfer(0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, w);
    xfer(0, 1'b1, 32'h08, 32'h0000_0000, 4'b0101, w);
    idle();
    chk("strb_reg2", rq0[2*32 +: 32], 32'hFF00_FF00);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, w);

    // error responses and zero-strobe write
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, w);
    xfer(0, 1'b1, 32'h02, 32'hDEAD_BEEF, 4'hF, w);
    xfer(0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 4'hF, w);
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, w);
    xfer(0, 1'b1, 32'h14, 32'hCAFE_F00D, 4'h0, w);
    idle();
    check_regs(0);

    // wait states on the second slave; RO status sampled at setup
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, w);         chk("ws_rd0_waits", w, 3);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, w);         chk("ws_ro_waits", w, 3);
    xfer(1, 1'b1, 32'h04, 32'h0BAD_F00D, 4'hF, w); chk("ws_wr_waits", w, 3);
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, w);
    idle();
    check_regs(1);

    // abort: psel drops in the middle of the wait phase
    sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    #4 chk("abort_wait_rdy", pready_m, 0);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    repeat (5) begin
      @(posedge pclk); #1;
      chk("abort_wp", wp1, 0);
    end
    check_regs(1);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, w); chk("post_abort_waits", w, 3);
    idle();

    // reset asserted in the completion cycle of a write
    sel = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h18; pwdata = 32'h1111_1111; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    #4 chk("rst_cmp_rdy", pready_m, 1);
    preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0; psel = 1'b0; penable = 1'b0;
    models_reset();
    chk("rst_cmp_reg6", rq0[6*32 +: 32], RSTV);
    chk("rst_cmp_wp", wp0, 0);
    chk("rst_cmp_prdata", bus0.prdata, 0);
    check_regs(0);
    check_regs(1);

    // three back-to-back writes, no idle cycle between them
    xfer(0, 1'b1, 32'h00, 32'h1111_0000, 4'hF, w); chk("b2b0_waits", w, 0);
    xfer(0, 1'b1, 32'h04, 32'h2222_0001, 4'hF, w); chk("b2b1_waits", w, 0);
    xfer(0, 1'b1, 32'h08, 32'h3333_0002, 4'hF, w); chk("b2b2_waits", w, 0);
    idle();
    check_regs(0);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
